// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Optional feature macro used by the arbiter top: FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width of the per-requester accepted-beat statistics counters.
    localparam int STATS_W = 16;

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Bits needed to index n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating-priority encoder: returns the first asserted request at an
// index >= rr_ptr, wrapping modulo NUM_REQ. Purely combinational.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               valid,
    output logic [IW-1:0]      idx
);

    // Walk the requests starting at rr_ptr; the first hit wins.
    always_comb begin
        int cand;
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(rr_ptr) + off) % NUM_REQ;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO write interface among
// NUM_REQ requesters. A grant is held for a whole burst, which ends on a
// last beat, on the MAX_BURST cap (0 = no cap) or on requester withdrawal.
// One IDLE bubble cycle always separates consecutive bursts.
// Optional build macro FIFO_ARB_STATS_EN adds per-requester saturating
// accepted-beat counters (beat_count) with a synchronous clear (stats_clr).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrate among pending requests, grant on next edge
// BURST | owner holds the FIFO write port; beats accepted while ~full
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8
) (
    input  logic                            wclk,
    input  logic                            wrst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            full,
    output logic                            w_en,
    output logic [DATA_WIDTH-1:0]           data_in,
    output logic [NUM_REQ-1:0]              grant,
`ifdef FIFO_ARB_STATS_EN
    input  logic                            stats_clr,
    output logic [NUM_REQ*STATS_W-1:0]      beat_count,
`endif
    output logic                            busy
);

    localparam int IW  = idx_width(NUM_REQ);
    localparam int BCW = cnt_width(MAX_BURST);

    // Cap value widened by one bit so beat_cnt+1 never wraps in the compare.
    localparam logic [BCW:0] CAP_VAL = (BCW + 1)'(MAX_BURST);

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;

    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic                 cap_hit;
    logic                 burst_end;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // The beat being accepted now is the last one the cap allows.
    assign cap_hit = (MAX_BURST != 0) &&
                     (({1'b0, beat_cnt_q} + 1'b1) == CAP_VAL);

    // Arbiter registers; reset drops any partial burst.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state logic plus the combinational FIFO/requester handshake.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        w_en       = 1'b0;
        req_ready  = '0;
        data_in    = '0;
        burst_end  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d           = BURST;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    beat_cnt_d        = '0;
                end
            end

            BURST: begin
                data_in            = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
                req_ready[owner_q] = ~full;
                w_en               = req[owner_q] & ~full;

                // Withdrawal ends the burst even while the FIFO is full.
                if (!req[owner_q]) begin
                    burst_end = 1'b1;
                end else if (w_en) begin
                    if (req_last[owner_q] || cap_hit) begin
                        burst_end = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end

                if (burst_end) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = (state_q == BURST);

`ifdef FIFO_ARB_STATS_EN
    logic [STATS_W-1:0] stat_q [NUM_REQ];

    // Per-requester accepted-beat counters; clear wins over increment,
    // and each counter sticks at all-ones instead of wrapping.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else if (stats_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && req_ready[i] && (stat_q[i] != '1)) begin
                    stat_q[i] <= stat_q[i] + 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats_out
        assign beat_count[gi*STATS_W +: STATS_W] = stat_q[gi];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// MAX_BURST=8). Inputs change 1 time unit after the rising edge; outputs are
// sampled one further time unit later.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 8;

    logic              wclk;
    logic              wrst_n;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              full;
    logic              w_en;
    logic [DW-1:0]     data_in;
    logic [NR-1:0]     grant;
    logic              busy;
`ifdef FIFO_ARB_STATS_EN
    logic              stats_clr;
    logic [NR*16-1:0]  beat_count;
`endif

    int tests_run;
    int tests_failed;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .full       (full),
        .w_en       (w_en),
        .data_in    (data_in),
        .grant      (grant),
`ifdef FIFO_ARB_STATS_EN
        .stats_clr  (stats_clr),
        .beat_count (beat_count),
`endif
        .busy       (busy)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic apply_reset();
        wrst_n   = 1'b0;
        req      = '0;
        req_last = '0;
        req_data = '0;
        full     = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        wrst_n   = 1'b0;
        req      = 4'b1111;
        req_last = '0;
        req_data = 32'hDEADBEEF;
        full     = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge wclk);
        #1;
        tests_run++;
        if (grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (w_en !== 1'b0) begin tests_failed++; $display("FAIL reset_w_en: got %b expected 0", w_en); end
        tests_run++;
        if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        tests_run++;
        if (data_in !== 8'h00) begin tests_failed++; $display("FAIL reset_data_in: got %h expected 00", data_in); end
        apply_reset();
    endtask

    task automatic test_single();
        int nw;
        nw = 0;
        req           = 4'b0001;
        req_data[7:0] = 8'hA1;
        req_last[0]   = 1'b0;
        #1;
        tests_run++;
        if (grant !== 4'b0000 || w_en !== 1'b0) begin tests_failed++; $display("FAIL single_idle: grant %b w_en %b expected 0000/0", grant, w_en); end
        step();
        #1;
        tests_run++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin tests_failed++; $display("FAIL single_grant: grant %b busy %b expected 0001/1", grant, busy); end
        tests_run++;
        if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
        for (int b = 0; b < 3; b++) begin
            req_data[7:0] = 8'hA1 + 8'(b);
            req_last[0]   = (b == 2);
            #1;
            if (w_en === 1'b1) nw++;
            tests_run++;
            if (w_en !== 1'b1 || data_in !== 8'hA1 + 8'(b)) begin
                tests_failed++;
                $display("FAIL single_beat%0d: w_en %b data %h expected 1/%h", b, w_en, data_in, 8'hA1 + 8'(b));
            end
            step();
        end
        req = '0;
        req_last = '0;
        #1;
        tests_run++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL single_release: grant %b busy %b expected 0000/0", grant, busy); end
        tests_run++;
        if (nw != 3) begin tests_failed++; $display("FAIL single_writes: got %0d expected 3", nw); end
        step();
    endtask

    task automatic test_contention();
        int nw;
        int idx;
        apply_reset();
        nw = 0;
        req      = 4'b1111;
        req_last = 4'b1111;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 8'h10 + 8'(i);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c < 8 && w_en === 1'b1) nw++;
            if (c % 2 == 1) begin
                idx = ((c - 1) / 2) % NR;
                tests_run++;
                if (grant !== (4'b0001 << idx) || w_en !== 1'b1 || data_in !== 8'h10 + 8'(idx)) begin
                    tests_failed++;
                    $display("FAIL contention_c%0d: grant %b w_en %b data %h expected %b/1/%h",
                             c, grant, w_en, data_in, 4'b0001 << idx, 8'h10 + 8'(idx));
                end
            end else begin
                tests_run++;
                if (grant !== 4'b0000 || w_en !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL contention_bubble_c%0d: grant %b w_en %b expected 0000/0", c, grant, w_en);
                end
            end
            step();
        end
        tests_run++;
        if (nw != 4) begin tests_failed++; $display("FAIL contention_writes: got %0d expected 4", nw); end
        req = '0;
        req_last = '0;
        step();
    endtask

    task automatic test_full_stall();
        int  nw;
        logic released;
        apply_reset();
        req            = 4'b0100;
        req_last       = '0;
        req_data[23:16] = 8'h22;
        step();
        for (int b = 0; b < 2; b++) begin
            #1;
            tests_run++;
            if (grant !== 4'b0100 || w_en !== 1'b1) begin tests_failed++; $display("FAIL stall_pre%0d: grant %b w_en %b expected 0100/1", b, grant, w_en); end
            step();
        end
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests_run++;
            if (w_en !== 1'b0 || req_ready !== 4'b0000 || grant !== 4'b0100) begin
                tests_failed++;
                $display("FAIL stall_full%0d: w_en %b ready %b grant %b expected 0/0000/0100", k, w_en, req_ready, grant);
            end
            step();
        end
        full = 1'b0;
        #1;
        tests_run++;
        if (w_en !== 1'b1 || req_ready !== 4'b0100) begin tests_failed++; $display("FAIL stall_resume: w_en %b ready %b expected 1/0100", w_en, req_ready); end
        nw = 0;
        released = 1'b0;
        for (int k = 0; k < 12 && !released; k++) begin
            #1;
            if (grant === 4'b0000) released = 1'b1;
            else if (w_en === 1'b1) nw++;
            if (!released) step();
        end
        tests_run++;
        if (!released || nw != 6) begin tests_failed++; $display("FAIL stall_cap_after_resume: released %b writes %0d expected 1/6", released, nw); end
        req = '0;
        step();
    endtask

    task automatic test_burst_cap();
        logic [3:0] exp_g [13];
        int nw1;
        exp_g = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                  4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
        apply_reset();
        req_data[7:0]  = 8'h0F;
        req_data[15:8] = 8'h5A;
        req_last       = 4'b0001;
        req            = 4'b0010;
        nw1 = 0;
        for (int c = 0; c < 13; c++) begin
            if (c == 1) req = 4'b0011;
            #1;
            if (grant === 4'b0010 && w_en === 1'b1 && c < 9) nw1++;
            tests_run++;
            if (grant !== exp_g[c] || w_en !== (exp_g[c] != 4'b0000)) begin
                tests_failed++;
                $display("FAIL cap_c%0d: grant %b w_en %b expected %b/%b", c, grant, w_en, exp_g[c], exp_g[c] != 4'b0000);
            end
            step();
        end
        tests_run++;
        if (nw1 != 8) begin tests_failed++; $display("FAIL cap_writes_req1: got %0d expected 8", nw1); end
        req = '0;
        step();
        step();
    endtask

    task automatic test_withdrawal();
        apply_reset();
        req      = 4'b1000;
        req_last = '0;
        req_data[31:24] = 8'h33;
        step();
        for (int b = 0; b < 2; b++) begin
            #1;
            tests_run++;
            if (grant !== 4'b1000 || w_en !== 1'b1) begin tests_failed++; $display("FAIL withdraw_beat%0d: grant %b w_en %b expected 1000/1", b, grant, w_en); end
            step();
        end
        req = 4'b0000;
        #1;
        tests_run++;
        if (w_en !== 1'b0 || grant !== 4'b1000) begin tests_failed++; $display("FAIL withdraw_drop: w_en %b grant %b expected 0/1000", w_en, grant); end
        step();
        req = 4'b1001;
        #1;
        tests_run++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL withdraw_release: grant %b busy %b expected 0000/0", grant, busy); end
        step();
        #1;
        tests_run++;
        if (grant !== 4'b0001) begin tests_failed++; $display("FAIL withdraw_rr_ptr: grant %b expected 0001", grant); end
        req = '0;
        step();
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        req      = 4'b0100;
        req_last = '0;
        req_data[23:16] = 8'h44;
        step();
        step();
        #1;
        tests_run++;
        if (w_en !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_pre: w_en %b expected 1", w_en); end
        wrst_n = 1'b0;
        #1;
        tests_run++;
        if (w_en !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0000 || data_in !== 8'h00) begin
            tests_failed++;
            $display("FAIL rst_mid_async: w_en %b grant %b busy %b ready %b data %h expected 0/0000/0/0000/00",
                     w_en, grant, busy, req_ready, data_in);
        end
        @(negedge wclk);
        wrst_n = 1'b1;
        step();
        tests_run++;
        if (grant !== 4'b0100) begin tests_failed++; $display("FAIL rst_mid_regrant: grant %b expected 0100", grant); end
        req = '0;
        step();
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        req      = 4'b0001;
        req_last = '0;
        step();
        for (int b = 0; b < 5; b++) begin
            req_last[0] = (b == 4);
            step();
        end
        req = 4'b0100;
        req_last = '0;
        step();
        step();
        req_last[2] = 1'b1;
        step();
        req = '0;
        req_last = '0;
        step();
        tests_run++;
        if (beat_count[15:0] !== 16'd5) begin tests_failed++; $display("FAIL stats_req0: got %0d expected 5", beat_count[15:0]); end
        tests_run++;
        if (beat_count[47:32] !== 16'd2) begin tests_failed++; $display("FAIL stats_req2: got %0d expected 2", beat_count[47:32]); end
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        tests_run++;
        if (beat_count !== '0) begin tests_failed++; $display("FAIL stats_clr: got %h expected 0", beat_count); end
        req = 4'b0001;
        repeat (79000) step();
        tests_run++;
        if (beat_count[15:0] !== 16'hFFFF) begin tests_failed++; $display("FAIL stats_saturate: got %h expected ffff", beat_count[15:0]); end
        req = '0;
        step();
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single();
        test_contention();
        test_full_stall();
        test_burst_cap();
        test_withdrawal();
        test_reset_mid_burst();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one asynchronous FIFO write interface among NUM_REQ requesters in the write clock domain. A grant is locked for a whole burst, which ends on a last beat, a burst-length cap or requester withdrawal. The arbiter drives the FIFO's w_en/data_in and obeys its full flag, so a beat is accepted only when the FIFO can take it. It sits between the producer blocks and the FIFO write side.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, FIFO data width
MAX_BURST, 8, max beats per grant; 0 = unlimited (last/withdrawal only)

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request/valid
req_data  in  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  in  NUM_REQ  marks final beat of requester's burst
req_ready  out  NUM_REQ  beat accepted this cycle when req[i] & req_ready[i]
full  in  1  FIFO full flag (write domain)
w_en  out  1  FIFO write enable
data_in  out  DATA_WIDTH  FIFO write data
grant  out  NUM_REQ  one-hot current owner (registered)
busy  out  1  high in BURST state

Behaviour:
- Clock/reset: single clock wclk; wrst_n asynchronous assert, synchronous deassert, active-low.
- Reset values: state=IDLE, grant=0, owner=0, rr_ptr=0, beat_cnt=0, busy=0. Outputs w_en=0, req_ready=0 and data_in=0 follow combinationally.
- States: IDLE, BURST.
- IDLE:
  - No beats are accepted.
  - If any req is high, choose the first requester at index >= rr_ptr, wrapping modulo NUM_REQ.
  - Next edge: grant/owner set, beat_cnt=0, state=BURST.
  - Arbitration latency is 1 cycle from req to grant.
- BURST, owner g:
  - req_ready[g] = ~full.
  - w_en = req[g] & ~full.
  - data_in = owner's req_data slice.
  - Non-owners: req_ready=0.
  - Accepted beat (w_en=1): beat_cnt increments.
- Burst end, any one of:
  - (a) accepted beat with req_last[g]=1.
  - (b) accepted beat making beat_cnt+1 == MAX_BURST (MAX_BURST != 0).
  - (c) req[g]=0 while in BURST (withdrawal; no beat that cycle).
- On burst end, next edge: state=IDLE, grant=0, rr_ptr=(g+1) mod NUM_REQ, beat_cnt=0.
- Bubble: exactly one IDLE cycle between bursts, even if requests are pending.
- full=1 in BURST: no accept, grant held, beat_cnt frozen, no timeout. The burst resumes when full drops.
- Simultaneous requests resolve in strict rotation. A lone requester is re-granted after the 1-cycle bubble.
- Requester protocol: req_data/req_last must stay stable while req=1 and the beat is not yet accepted.
- Reset mid-burst: immediately IDLE, grant=0, w_en=0 combinationally. The partial burst is dropped and producers must restart.
- Widths:
  - beat_cnt is $clog2(MAX_BURST+1) bits, minimum 1.
  - rr_ptr and owner are $clog2(NUM_REQ) bits.
  - rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
FIFO_ARB_STATS_EN
- Defined: adds output beat_count, NUM_REQ*16 bits, per-requester saturating counters.
  - Counter i increments on each beat accepted from requester i.
  - Counters hold at 16'hFFFF.
  - Reset to 0 by wrst_n.
  - Adds input stats_clr (1 bit), a synchronous clear of all counters that takes priority over increment.
- Undefined: neither port exists, no counter logic.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, BURST}.
  - Localparam helpers for counter width.
  - Stats counter width constant STATS_W=16.
- Sub-module rr_picker: combinational rotating-priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: valid, owner index.
  - Instantiated once.

Test Plan:
- Single requester: req[0]=1, 3 beats with last on beat 3, full=0 -> grant=0001 one cycle after req, 3 consecutive w_en pulses with data_in = req_data[0] beats, then grant=0, busy=0.
- Contention: req=1111 continuously, each burst 1 beat with last=1 -> owner order 0,1,2,3,0.
  - Each grant lasts 1 cycle, each followed by 1 IDLE cycle.
  - Exactly 4 writes in 8 cycles.
- Full stall: owner 2 mid-burst, full=1 for 5 cycles -> w_en=0 and req_ready[2]=0 for those cycles, grant held, beat_cnt unchanged; writes resume the cycle full=0.
- Burst cap: MAX_BURST=8, requester 1 streams 12 beats with last never set, req=0011 -> 8 writes from req 1, release, req 0 granted, then req 1 resumes.
- Withdrawal and reset: owner 3 drops req after 2 beats -> release, rr_ptr=0.
  - Separately, wrst_n=0 mid-burst -> w_en=0 immediately, grant=0, state IDLE.
- Stats (FIFO_ARB_STATS_EN): 5 beats from req 0 and 2 from req 2 -> beat_count[0]=5, [2]=2.
  - stats_clr pulse -> all counters 0.
  - Forcing 70000 beats -> counter holds at 16'hFFFF.
